dispatch_queue: RTL and testbench



---
 rtl/dispatch_queue_pkg.sv | 14 +
 rtl/dq_lane_compact.sv | 26 ++
 rtl/dispatch_queue.sv | 99 +++++++++
 tb/tb_dispatch_queue.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dispatch_queue_pkg.sv
// dispatch_queue_pkg: shared widths, types and lane-mask helpers for the dispatch queue
package dispatch_queue_pkg;
    localparam int DQ_INST_W = 56;
    localparam int DQ_LANES  = 4;
    typedef logic [DQ_INST_W-1:0] dq_inst_t;
    typedef logic [DQ_LANES-1:0]  dq_lane_mask_t;
    function automatic logic [2:0] popcount4(input dq_lane_mask_t m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction
    // Count to thermometer mask: 0 -> 0000, 2 -> 0011, 4+ -> 1111.
    function automatic dq_lane_mask_t therm4(input logic [2:0] n);
        return n >= 3'd4 ? 4'b1111 : 4'((5'd1 << n) - 5'd1);
    endfunction
endpackage

// File: rtl/dq_lane_compact.sv
// dq_lane_compact: packs valid lanes toward lane 0 in lane order
//   mask  : per-lane valid
//   lanes : incoming instructions, lane 0 oldest
//   packed_lanes : valid lanes compacted, unused slots zero
//   cnt   : number of valid lanes
module dq_lane_compact
    import dispatch_queue_pkg::*;
(
    input  dq_lane_mask_t               mask,
    input  dq_inst_t [DQ_LANES-1:0]     lanes,
    output dq_inst_t [DQ_LANES-1:0]     packed_lanes,
    output logic [2:0]                  cnt
);
    logic [2:0] idx;
    always_comb begin
        packed_lanes = '0;
        idx = 3'd0;
        for (int i = 0; i < DQ_LANES; i++) begin
            if (mask[i]) begin
                packed_lanes[idx[1:0]] = lanes[i];
                idx = idx + 3'd1;
            end
        end
        cnt = popcount4(mask);
    end
endmodule

// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order circular buffer between allocation and the scheduler
//   inst_in0..3 / inst_vld_in : up to 4 renamed instructions per cycle, lane 0 oldest
//   flush_in    : misprediction flush, empties the queue next cycle
//   sch_full_in : scheduler stall, suppresses presentation
//   inst_out0..3 / vld_out : oldest entries, thermometer-coded valid
//   full_out / empty_out / ovf_err_out : back-pressure, empty, sticky overflow
// Optional: DISPATCH_QUEUE_BYPASS_EN routes inputs straight to outputs when empty.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int INST_W = DQ_INST_W,
    parameter int LANES  = DQ_LANES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] inst_in0,
    input  logic [INST_W-1:0] inst_in1,
    input  logic [INST_W-1:0] inst_in2,
    input  logic [INST_W-1:0] inst_in3,
    input  logic [LANES-1:0]  inst_vld_in,
    input  logic              flush_in,
    input  logic              sch_full_in,
    output logic [INST_W-1:0] inst_out0,
    output logic [INST_W-1:0] inst_out1,
    output logic [INST_W-1:0] inst_out2,
    output logic [INST_W-1:0] inst_out3,
    output logic [LANES-1:0]  vld_out,
    output logic              full_out,
    output logic              empty_out,
    output logic              ovf_err_out
);
    localparam int AW = $clog2(DEPTH);
    logic [INST_W-1:0] mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0] count;
    logic ovf;
    dq_inst_t [DQ_LANES-1:0] cmp;
    logic [2:0] n_in, n_avail, n_deq;
    logic full_raw, deq, byp, wr;
    logic [INST_W-1:0] lane_q [LANES];

    dq_lane_compact u_compact (
        .mask         (inst_vld_in),
        .lanes        ({inst_in3, inst_in2, inst_in1, inst_in0}),
        .packed_lanes (cmp),
        .cnt          (n_in)
    );

    always_comb begin
        byp = 1'b0;
`ifdef DISPATCH_QUEUE_BYPASS_EN
        byp = !rst && count == '0 && !flush_in && !sch_full_in;
`endif
        // Back-pressure looks only at registered occupancy, never at this cycle's dequeue.
        full_raw = int'(count) > DEPTH - LANES;
        n_avail = int'(count) >= LANES ? 3'd4 : count[2:0];
        deq = !rst && !flush_in && !sch_full_in;
        n_deq = deq ? n_avail : 3'd0;
        vld_out = byp ? therm4(n_in) : therm4(n_deq);
        for (int i = 0; i < LANES; i++)
            lane_q[i] = !vld_out[i] ? '0 : byp ? cmp[i] : mem[head + AW'(i)];
        wr = !rst && !flush_in && !byp && !full_raw && n_in != 3'd0;
    end

    assign inst_out0   = lane_q[0];
    assign inst_out1   = lane_q[1];
    assign inst_out2   = lane_q[2];
    assign inst_out3   = lane_q[3];
    assign full_out    = !rst && full_raw;
    assign empty_out   = rst || count == '0;
    assign ovf_err_out = ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(n_deq);
            tail  <= wr ? tail + AW'(n_in) : tail;
            count <= count + (wr ? (AW+1)'(n_in) : '0) - (AW+1)'(n_deq);
            if (n_in != 3'd0 && full_raw)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            for (int k = 0; k < LANES; k++)
                if (3'(k) < n_in)
                    mem[tail + AW'(k)] <= cmp[k];
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed self-checking bench for dispatch_queue (DEPTH=16)
module tb_dispatch_queue;
    logic clk = 1'b0;
    logic rst;
    logic [55:0] in0, in1, in2, in3, out0, out1, out2, out3;
    logic [3:0] vld_in, vld_out;
    logic flush, sch_full, full, empty, ovf;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dispatch_queue dut (
        .clk(clk), .rst(rst),
        .inst_in0(in0), .inst_in1(in1), .inst_in2(in2), .inst_in3(in3),
        .inst_vld_in(vld_in), .flush_in(flush), .sch_full_in(sch_full),
        .inst_out0(out0), .inst_out1(out1), .inst_out2(out2), .inst_out3(out3),
        .vld_out(vld_out), .full_out(full), .empty_out(empty), .ovf_err_out(ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] m, input logic [55:0] a, b, c, d);
        vld_in = m; in0 = a; in1 = b; in2 = c; in3 = d;
        #1;
    endtask

    task automatic push(input logic [3:0] m, input logic [55:0] a, b, c, d);
        drive(m, a, b, c, d);
        tick();
        vld_in = 4'b0000;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; sch_full = 1'b0;
        vld_in = 4'b0000; in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        tick();
        #1;
        chk("rst_vld", 64'(vld_out), 64'h0);
        chk("rst_empty", 64'(empty), 64'h1);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_out0", 64'(out0), 64'h0);
        rst = 1'b0;
        tick();
        chk("idle_ovf", 64'(ovf), 64'h0);

        // full group of four
        drive(4'b1111, 56'hA, 56'hB, 56'hC, 56'hD);
`ifdef DISPATCH_QUEUE_BYPASS_EN
        chk("t1_byp_vld", 64'(vld_out), 64'hF);
        chk("t1_byp_d3", 64'(out3), 64'hD);
        tick();
        vld_in = 4'b0000;
        #1;
`else
        chk("t1_lat_vld", 64'(vld_out), 64'h0);
        tick();
        vld_in = 4'b0000;
        #1;
        chk("t1_vld", 64'(vld_out), 64'hF);
        chk("t1_empty", 64'(empty), 64'h0);
        chk("t1_out", {out3[15:0], out2[15:0], out1[15:0], out0[15:0]}, 64'h000D_000C_000B_000A);
        tick();
`endif
        chk("t1_drained", 64'(empty), 64'h1);
        chk("t1_vld0", 64'(vld_out), 64'h0);

        // sparse mask compaction
        sch_full = 1'b1;
        push(4'b1010, 56'h1, 56'hE1, 56'h3, 56'hE2);
        chk("t2_stall_vld", 64'(vld_out), 64'h0);
        chk("t2_empty", 64'(empty), 64'h0);
        sch_full = 1'b0;
        #1;
        chk("t2_vld", 64'(vld_out), 64'h3);
        chk("t2_out0", 64'(out0), 64'hE1);
        chk("t2_out1", 64'(out1), 64'hE2);
        chk("t2_out2", 64'(out2), 64'h0);
        tick();
        chk("t2_drained", 64'(empty), 64'h1);

        // fill to 13 (head=tail=6), overflow drop
        sch_full = 1'b1;
        push(4'b1111, 56'h100, 56'h101, 56'h102, 56'h103);
        push(4'b1111, 56'h104, 56'h105, 56'h106, 56'h107);
        push(4'b1111, 56'h108, 56'h109, 56'h10A, 56'h10B);
        chk("t3_full12", 64'(full), 64'h0);
        push(4'b0001, 56'h10C, 56'h0, 56'h0, 56'h0);
        chk("t3_full13", 64'(full), 64'h1);
        chk("t3_ovf_pre", 64'(ovf), 64'h0);
        push(4'b0001, 56'hBAD, 56'h0, 56'h0, 56'h0);
        chk("t3_ovf", 64'(ovf), 64'h1);
        chk("t3_full_kept", 64'(full), 64'h1);
        sch_full = 1'b0;
        #1;
        chk("t3_d1_vld", 64'(vld_out), 64'hF);
        chk("t3_d1_out0", 64'(out0), 64'h100);
        tick();
        chk("t3_d2_out3", 64'(out3), 64'h107);
        tick();
        chk("t3_wrap_out0", 64'(out0), 64'h108);
        chk("t3_wrap_out3", 64'(out3), 64'h10B);
        tick();
        chk("t3_last_vld", 64'(vld_out), 64'h1);
        chk("t3_last_out0", 64'(out0), 64'h10C);
        chk("t3_ovf_sticky", 64'(ovf), 64'h1);
        tick();
        chk("t3_drained", 64'(empty), 64'h1);

        // advance head to 14 (head=tail=3 now)
        sch_full = 1'b1;
        push(4'b1111, 56'h0, 56'h0, 56'h0, 56'h0);
        push(4'b1111, 56'h0, 56'h0, 56'h0, 56'h0);
        push(4'b0111, 56'h0, 56'h0, 56'h0, 56'h0);
        sch_full = 1'b0;
        tick();
        tick();
        tick();
        chk("t4_empty", 64'(empty), 64'h1);
        sch_full = 1'b1;
        push(4'b1111, 56'h200, 56'h201, 56'h202, 56'h203);
        push(4'b0011, 56'h204, 56'h205, 56'h0, 56'h0);
        sch_full = 1'b0;
        #1;
        chk("t4_vld", 64'(vld_out), 64'hF);
        chk("t4_out", {out3[15:0], out2[15:0], out1[15:0], out0[15:0]}, 64'h0203_0202_0201_0200);
        tick();
        chk("t4_rest_vld", 64'(vld_out), 64'h3);
        chk("t4_rest_out0", 64'(out0), 64'h204);
        chk("t4_rest_out1", 64'(out1), 64'h205);
        tick();
        chk("t4_drained", 64'(empty), 64'h1);

        // flush with count=10 and a simultaneous push
        sch_full = 1'b1;
        push(4'b1111, 56'h300, 56'h301, 56'h302, 56'h303);
        push(4'b1111, 56'h304, 56'h305, 56'h306, 56'h307);
        push(4'b0011, 56'h308, 56'h309, 56'h0, 56'h0);
        sch_full = 1'b0;
        flush = 1'b1;
        drive(4'b1111, 56'h3F0, 56'h3F1, 56'h3F2, 56'h3F3);
        chk("t5_flush_vld", 64'(vld_out), 64'h0);
        tick();
        flush = 1'b0;
        vld_in = 4'b0000;
        #1;
        chk("t5_empty", 64'(empty), 64'h1);
        chk("t5_vld", 64'(vld_out), 64'h0);
        chk("t5_ovf", 64'(ovf), 64'h1);
        sch_full = 1'b1;
        push(4'b0100, 56'h0, 56'h0, 56'h400, 56'h0);
        sch_full = 1'b0;
        #1;
        chk("t5_after_vld", 64'(vld_out), 64'h1);
        chk("t5_after_out0", 64'(out0), 64'h400);
        tick();

`ifdef DISPATCH_QUEUE_BYPASS_EN
        drive(4'b0111, 56'h500, 56'h501, 56'h502, 56'h0);
        chk("t6_byp_vld", 64'(vld_out), 64'h7);
        chk("t6_byp_out", {out3[15:0], out2[15:0], out1[15:0], out0[15:0]}, 64'h0000_0502_0501_0500);
        chk("t6_byp_empty", 64'(empty), 64'h1);
        tick();
        vld_in = 4'b0000;
        #1;
        chk("t6_empty", 64'(empty), 64'h1);
        chk("t6_vld", 64'(vld_out), 64'h0);
`endif

        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("final_ovf_clr", 64'(ovf), 64'h0);
        chk("final_empty", 64'(empty), 64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
